period_meter: RTL and testbench
===============================

// Module: period_meter
// PURPOSE
//   Receive-side companion of the clock divider: samples a slow divided signal
//   (e.g. the 1 Hz q output of the 50 MHz divider), measures its period and high
//   time in clk cycles, and flags in-range / loss-of-signal. Sits on the board clk
//   domain; sig_in is treated as asynchronous. Used as a self-check on divider outputs.
// PARAMETERS
//   CNT_W        27          counter/measurement width (covers 2x 50e6 cycles)
//   EXP_PERIOD   50_000_000  expected sig_in period in clk cycles
//   TOL          1000        allowed |period - EXP_PERIOD| for in_range
//   TIMEOUT_CYC  100_000_000 cycles without a rising edge before lost asserts (< 2^CNT_W)
// PORTS
//   clk        in   1      system clock, all logic on rising edge
//   reset      in   1      asynchronous, active-high reset
//   en         in   1      measurement enable; 0 forces IDLE
//   sig_in     in   1      asynchronous divided signal under measurement
//   period     out  CNT_W  last measured period (rise-to-rise), clk cycles
//   high_time  out  CNT_W  last measured high time (rise-to-fall), clk cycles
//   meas_valid out  1      1-cycle pulse: period/in_range just updated
//   in_range   out  1      last period within EXP_PERIOD +/- TOL
//   lost       out  1      sticky: timeout since last rise, cleared by next meas_valid
// BEHAVIOUR
//   Reset (async, immediate): all regs and outputs = 0, FSM = IDLE, sync regs = 0.
//   Input path: 2-FF synchronizer s1->s2, then s3 <= s2. rise = s2 & ~s3,
//     fall = ~s2 & s3. Edge pulse appears 3 clk after sig_in changes at the
//     first FF; pulses shorter than 1 clk may be missed (not an error).
//   FSM states:
//     IDLE    : cnt = 0. On rise & en -> MEASURE, cnt <= 1. No capture.
//     MEASURE : cnt <= cnt+1 each cycle.
//       rise       -> period <= cnt, cnt <= 1, meas_valid next cycle, in_range
//                     <= (|cnt-EXP_PERIOD| <= TOL), lost <= 0. Stay MEASURE.
//       fall       -> high_time <= cnt (no meas_valid pulse for high_time).
//       cnt == TIMEOUT_CYC & no rise -> lost <= 1, in_range <= 0, -> IDLE.
//       period/high_time hold their last values on timeout.
//   Counting: edges N clk apart at rise-pulse level give period = N exactly.
//     Difference for in_range computed at CNT_W+1 bits signed, no wraparound.
//     cnt never exceeds TIMEOUT_CYC, so no overflow.
//   Simultaneous: rise and cnt==TIMEOUT_CYC same cycle -> rise wins (valid
//     measurement, no lost). rise and fall cannot coincide.
//   meas_valid, period and in_range update together; meas_valid high exactly
//     1 cycle per captured period. First rise after IDLE never produces valid.
//   en = 0: FSM -> IDLE next cycle, cnt <= 0, period/high_time/in_range/lost
//     hold; sync chain keeps running so re-enable sees no false edge.
//   Reset mid-measurement: everything cleared; next valid requires two rises.
// TESTING (sim params: EXP_PERIOD=10, TOL=1, TIMEOUT_CYC=32, CNT_W=8)
//   1. sig_in toggles every 5 clk after reset -> first rise no valid; then
//      meas_valid each 10 clk, period=10, high_time=5, in_range=1, lost=0.
//   2. sig_in high 4 / low 8 clk -> period=12, high_time=4, in_range=0;
//      period 11 -> in_range=1 (tolerance boundary).
//   3. Stop sig_in low after a rise -> lost=1 exactly 32 clk after that rise
//      (measured at rise pulse), period holds 10; restart -> first rise no valid,
//      second rise gives meas_valid, lost=0.
//   4. Edge arriving on the cycle cnt==32 -> meas_valid with period=32, lost stays 0.
//   5. Assert reset for 1 clk mid-period -> all outputs 0 asynchronously; next
//      meas_valid only after two further rises.
//   6. en=0 for 20 clk during toggling -> no meas_valid, outputs hold; en=1 ->
//      first meas_valid on second rise after re-enable.

Source files
------------

// File: rtl/period_meter.sv
// Measures period (rise-to-rise) and high time (rise-to-fall) of an asynchronous
// slow signal in clk cycles, with in-range flag and sticky loss-of-signal.
module period_meter #(
  parameter int CNT_W       = 27,
  parameter int EXP_PERIOD  = 50_000_000,
  parameter int TOL         = 1000,
  parameter int TIMEOUT_CYC = 100_000_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sig_in,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             meas_valid,
  output logic             in_range,
  output logic             lost
);

  typedef enum logic {IDLE, MEASURE} state_t;

  localparam logic signed [CNT_W:0] EXP_S = (CNT_W+1)'(EXP_PERIOD);
  localparam logic signed [CNT_W:0] TOL_S = (CNT_W+1)'(TOL);
  localparam logic [CNT_W-1:0]      TO_C  = CNT_W'(TIMEOUT_CYC);

  logic s1, s2, s3;
  logic rise, fall;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [CNT_W-1:0] period_nxt, high_time_nxt;
  logic             mv_nxt, ir_nxt, lost_nxt;

  logic signed [CNT_W:0] diff, adiff;
  logic                  cnt_ok;

  // Sync chain runs independent of en so re-enable never sees a stale edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= sig_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise = s2 & ~s3;
  assign fall = ~s2 & s3;

  // One bit of headroom keeps the signed difference from wrapping.
  assign diff   = $signed({1'b0, cnt}) - EXP_S;
  assign adiff  = (diff < 0) ? -diff : diff;
  assign cnt_ok = (adiff <= TOL_S);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      period     <= '0;
      high_time  <= '0;
      meas_valid <= 1'b0;
      in_range   <= 1'b0;
      lost       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      period     <= period_nxt;
      high_time  <= high_time_nxt;
      meas_valid <= mv_nxt;
      in_range   <= ir_nxt;
      lost       <= lost_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    period_nxt    = period;
    high_time_nxt = high_time;
    mv_nxt        = 1'b0;
    ir_nxt        = in_range;
    lost_nxt      = lost;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en && rise) begin
          state_nxt = MEASURE;
          cnt_nxt   = CNT_W'(1);
        end
      end
      MEASURE: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (rise) begin
          // A rise on the timeout cycle is still a valid measurement.
          period_nxt = cnt;
          cnt_nxt    = CNT_W'(1);
          mv_nxt     = 1'b1;
          ir_nxt     = cnt_ok;
          lost_nxt   = 1'b0;
        end else if (cnt == TO_C) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          lost_nxt  = 1'b1;
          ir_nxt    = 1'b0;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
          if (fall) high_time_nxt = cnt;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter: time-stamp reference model checked every cycle, plus
// literal checks of the directed scenarios and a randomized waveform phase.
module tb_period_meter;
  localparam int CNT_W = 8;
  localparam int EXP   = 10;
  localparam int TOL   = 1;
  localparam int TO    = 32;

  logic             clk = 1'b0;
  logic             reset, en, sig_in;
  logic [CNT_W-1:0] period, high_time;
  logic             meas_valid, in_range, lost;

  int total = 0;
  int bad   = 0;
  int mv_cnt = 0;

  always #5 clk = ~clk;

  period_meter #(.CNT_W(CNT_W), .EXP_PERIOD(EXP), .TOL(TOL), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .en(en), .sig_in(sig_in),
    .period(period), .high_time(high_time), .meas_valid(meas_valid),
    .in_range(in_range), .lost(lost)
  );

  // Model: edges are sig_in samples delayed through the input path; measurements
  // are differences of cycle timestamps between edges.
  bit hq[$] = {1'b0, 1'b0, 1'b0};
  int cyc = 0, t0 = 0;
  bit act = 0;
  int m_per = 0, m_ht = 0;
  bit m_mv = 0, m_ir = 0, m_lost = 0;

  always @(posedge clk) begin
    bit r, f;
    int n;
    r = hq[1] && !hq[2];
    f = !hq[1] && hq[2];
    m_mv = 0;
    if (reset) begin
      hq = {1'b0, 1'b0, 1'b0};
      act = 0; m_per = 0; m_ht = 0; m_ir = 0; m_lost = 0;
    end else begin
      hq.push_front(sig_in);
      void'(hq.pop_back());
      n = cyc - t0;
      if (!en) act = 0;
      else if (!act) begin
        if (r) begin act = 1; t0 = cyc; end
      end else if (r) begin
        m_per = n; m_mv = 1; m_lost = 0; t0 = cyc;
        m_ir = (n >= EXP - TOL) && (n <= EXP + TOL);
      end else if (n == TO) begin
        m_lost = 1; m_ir = 0; act = 0;
      end else if (f) m_ht = n;
    end
    cyc++;
    #1;
    total++;
    if (meas_valid) mv_cnt++;
    if (period !== CNT_W'(m_per) || high_time !== CNT_W'(m_ht) || meas_valid !== m_mv ||
        in_range !== m_ir || lost !== m_lost) begin
      bad++;
      $display("FAIL cycle%0d: got per=%0d ht=%0d mv=%b ir=%b lost=%b, want per=%0d ht=%0d mv=%b ir=%b lost=%b",
               cyc, period, high_time, meas_valid, in_range, lost, m_per, m_ht, m_mv, m_ir, m_lost);
    end
  end

  task automatic chk(input string nm, input int act_v, input int exp_v);
    total++;
    if (act_v != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act_v, exp_v);
    end
  endtask

  task automatic step(input bit s, input bit e);
    @(negedge clk);
    sig_in = s;
    en = e;
  endtask

  task automatic wave(input int hi, input int lo, input int n, input bit e);
    repeat (n) begin
      repeat (hi) step(1'b1, e);
      repeat (lo) step(1'b0, e);
    end
  endtask

  initial begin
    int base, hi, lo;
    bit e;
    reset = 1'b1; en = 1'b1; sig_in = 1'b0;
    #1;
    chk("rst_period", period, 0);
    chk("rst_high", high_time, 0);
    chk("rst_lost", lost, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // 5/5 toggling: first rise only arms
    base = mv_cnt;
    wave(5, 5, 6, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s1_valids", mv_cnt - base, 5);
    chk("s1_period", period, 10);
    chk("s1_high", high_time, 5);
    chk("s1_inrange", in_range, 1);
    chk("s1_lost", lost, 0);

    // out of range, then tolerance boundary
    wave(4, 8, 3, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s2_period12", period, 12);
    chk("s2_high4", high_time, 4);
    chk("s2_inrange12", in_range, 0);
    wave(5, 6, 3, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s2_period11", period, 11);
    chk("s2_inrange11", in_range, 1);

    // loss of signal, then restart
    wave(5, 5, 2, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (40) step(1'b0, 1'b1);
    chk("s3_lost", lost, 1);
    chk("s3_period_hold", period, 10);
    chk("s3_inrange", in_range, 0);
    base = mv_cnt;
    wave(5, 5, 3, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s3_restart_valids", mv_cnt - base, 2);
    chk("s3_lost_clr", lost, 0);

    // rise exactly on the timeout cycle
    base = mv_cnt;
    wave(16, 16, 3, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s4_valids", mv_cnt - base, 3);
    chk("s4_period32", period, 32);
    chk("s4_lost", lost, 0);
    chk("s4_high16", high_time, 16);

    // reset mid-period
    wave(5, 5, 2, 1'b1);
    repeat (5) step(1'b1, 1'b1);
    repeat (2) step(1'b0, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("s5_period0", period, 0);
    chk("s5_high0", high_time, 0);
    chk("s5_mv0", meas_valid, 0);
    chk("s5_ir0", in_range, 0);
    chk("s5_lost0", lost, 0);
    @(negedge clk);
    reset = 1'b0;
    base = mv_cnt;
    repeat (3) step(1'b0, 1'b1);
    wave(5, 5, 1, 1'b1);
    chk("s5_one_rise", mv_cnt - base, 0);
    wave(5, 5, 1, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s5_two_rises", mv_cnt - base, 1);

    // enable gap during toggling
    wave(5, 5, 2, 1'b1);
    base = mv_cnt;
    wave(5, 5, 2, 1'b0);
    chk("s6_no_valid", mv_cnt - base, 0);
    chk("s6_period_hold", period, 10);
    wave(5, 5, 3, 1'b1);
    repeat (3) step(1'b0, 1'b1);
    chk("s6_reenable_valids", mv_cnt - base, 2);

    // randomized waveforms, occasional enable drops and timeouts
    repeat (80) begin
      hi = $urandom_range(1, 20);
      lo = $urandom_range(1, 20);
      e  = ($urandom_range(0, 5) != 0);
      wave(hi, lo, 1, e);
    end
    repeat (40) step(1'b0, 1'b1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
